// File: rtl/m_uart_tx.sv
// rtl/m_uart_tx.sv - 8N1 UART transmitter with a built-in bit-period counter.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frame).
module m_uart_tx #(
  parameter int UART_BPS_RATE = 115200,
  parameter int CLK_PERIORD   = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_uart_tx
);

  localparam int          BIT_CNT_MAX_I = 1_000_000_000 / UART_BPS_RATE / CLK_PERIORD - 1;
  localparam logic [15:0] BIT_CNT_MAX   = 16'(BIT_CNT_MAX_I);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_line;
  logic        tx_done;
`ifdef UART_TX_PARITY_EN
  logic        par_bit;
`endif

  logic bit_end;
  assign bit_end = (bit_cnt == BIT_CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx_line <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state == ST_IDLE || bit_end) begin
        bit_cnt <= 16'd0;
      end else begin
        bit_cnt <= bit_cnt + 16'd1;
      end

      // The line register is loaded with the next bit's value at each bit
      // boundary so the pin never depends combinationally on the inputs.
      case (state)
        ST_IDLE: begin
          tx_line <= 1'b1;
          if (i_tx_valid) begin
            shift   <= i_tx_data;
            bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^i_tx_data;
`endif
            tx_line <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_line <= shift[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_line <= par_bit;
              state   <= ST_PARITY;
`else
              tx_line <= 1'b1;
              state   <= ST_STOP;
`endif
            end else begin
              tx_line <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx_line <= 1'b1;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            tx_line <= 1'b1;
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          tx_line <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready = (state == ST_IDLE);
  assign o_tx_busy  = (state != ST_IDLE);
  assign o_tx_done  = tx_done;
  assign o_uart_tx  = tx_line;

endmodule

// File: tb/tb_m_uart_tx.sv
// tb/tb_m_uart_tx.sv - directed and randomized frame checks for m_uart_tx.
module tb_m_uart_tx;

  localparam int N = 1_000_000_000 / 115200 / 20;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'd0;
  logic       ready, busy, done, line;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_acc = 0;

  m_uart_tx dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_valid (valid),
    .i_tx_data  (data),
    .o_tx_ready (ready),
    .o_tx_busy  (busy),
    .o_tx_done  (done),
    .o_uart_tx  (line)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame bit i of byte b: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == NB - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit hold_next,
                            input logic [7:0] next_b, input int glitch_t);
    int hi_run;
    int done_early;
    valid = 1'b1;
    data  = b;
    tick();
    last_acc = cyc;
    chk("accept_line", 32'(line), 32'd0);
    chk("accept_ready", 32'(ready), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    if (hold_next) data = next_b;
    else begin
      valid = 1'b0;
      data  = 8'($urandom);
    end
    hi_run = 0;
    done_early = 0;
    for (int t = 1; t <= F; t++) begin
      if (t == glitch_t) begin
        valid = 1'b1;
        data  = 8'h3C;
      end
      if (t == glitch_t + 1) valid = 1'b0;
      tick();
      if (t < F && done) done_early++;
      if (t >= (NB - 1) * N && line) hi_run++;
      if (t % N == N / 2)
        chk($sformatf("bit%0d_of_%02h", t / N, b), 32'(line), 32'(exp_bit(b, t / N)));
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_end", 32'(ready), 32'd1);
    chk("done_early", 32'(done_early), 32'd0);
    chk("stop_high_len", 32'(hi_run), 32'(N + 1));
  endtask

  task automatic idle_after();
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_line", 32'(line), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int a;
    int d;

    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_line", 32'(line), 32'd1);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    send_frame(8'hA5, 1'b0, 8'h00, -10);
    idle_after();

    send_frame(8'h00, 1'b1, 8'hFF, -10);
    a = last_acc;
    send_frame(8'hFF, 1'b0, 8'h00, -10);
    chk("b2b_gap", 32'(last_acc - a), 32'(F + 1));
    idle_after();

    send_frame(8'h81, 1'b0, 8'h00, 3 * N + 100);
    idle_after();
    repeat (20) tick();
    chk("glitch_no_frame", 32'(busy), 32'd0);

    valid = 1'b1;
    data  = 8'h55;
    tick();
    valid = 1'b0;
    repeat (4 * N + N / 2) tick();
    chk("mid_bit3_line", 32'(line), 32'(exp_bit(8'h55, 4)));
    rst_n = 1'b0;
    tick();
    chk("midrst_line", 32'(line), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    d = 0;
    for (int i = 0; i < F; i++) begin
      tick();
      if (done || busy) d++;
    end
    chk("midrst_quiet", 32'(d), 32'd0);
    send_frame(8'h12, 1'b0, 8'h00, -10);
    idle_after();

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, 1'b0, 8'h00, -10);
    idle_after();
    send_frame(8'h03, 1'b0, 8'h00, -10);
    idle_after();
`endif

    for (int r = 0; r < 3; r++) begin
      send_frame(8'($urandom), 1'b0, 8'h00, int'($urandom_range(1, F - 2)));
      idle_after();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/m_uart_tx.md
# m_uart_tx

UART transmitter that serialises one byte per valid/ready handshake into an 8N1 frame on `o_uart_tx`. It sits on the transmit side of the UART path and pairs with the receive-side baud generator. It owns its own bit-period counter, so it needs no external baud strobe. The bit period is derived from the same baud-rate and clock-period parameters used on the receive side.

## Interface
- `UART_BPS_RATE`, default 115200: baud rate in bit/s; must be ≤ 115200.
- `CLK_PERIORD`, default 20: `i_clk` period in ns.
- Derived constant `BIT_CNT_MAX` = 1_000_000_000/`UART_BPS_RATE`/`CLK_PERIORD` − 1, using integer division (433 at defaults). One bit lasts `BIT_CNT_MAX`+1 cycles.

Ports:
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, synchronous, active-low; clock `i_clk`.
- `i_tx_valid` input 1: byte offered on `i_tx_data`.
- `i_tx_data` input 8: byte to send, LSB first.
- `o_tx_ready` output 1: block can accept a byte.
- `o_tx_busy` output 1: frame in progress.
- `o_tx_done` output 1: one-cycle pulse when the stop bit completes.
- `o_uart_tx` output 1: serial line, idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE**
  - `o_tx_ready`=1, `o_uart_tx`=1.
  - Accept occurs on an edge where `i_tx_valid` && `o_tx_ready`.
  - On accept: latch `i_tx_data` into the shift register, clear the bit counter and bit index, go to START.
- **START**: line=0 for one bit period, then go to DATA.
- **DATA**
  - Line=shift[0]. At the end of each bit period, shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY (if enabled) or STOP.
- **PARITY**: line=even parity of the latched byte for one bit period, then go to STOP.
- **STOP**: line=1 for one bit period, then go to IDLE and pulse `o_tx_done`.
- Bit counter
  - 16-bit, counts 0..`BIT_CNT_MAX`, then wraps to 0 and advances the bit.
  - It is held at 0 in IDLE.
  - `BIT_CNT_MAX` must fit in 16 bits.
- `o_tx_busy` = (state ≠ IDLE). `o_tx_ready` = (state == IDLE).
- `i_tx_valid` is ignored while not ready. `i_tx_data` may change after accept without affecting the frame.
- `o_uart_tx` is a register output, with no combinational path from the inputs.

## Timing
- Reset values:
  - state=IDLE
  - `o_uart_tx`=1
  - `o_tx_ready`=1
  - `o_tx_busy`=0
  - `o_tx_done`=0
  - counter and index = 0
- Reset asserted mid-frame:
  - At the next edge, the line returns to 1 and the state to IDLE.
  - The partial frame is abandoned, and no `o_tx_done` pulse is produced.
- Accept at edge k:
  - From k, `o_uart_tx`=0 and `o_tx_ready`=0.
  - The start bit occupies cycles k+1 … k+N, where N=`BIT_CNT_MAX`+1.
- Data bit i occupies cycles k+1+(i+1)·N … k+(i+2)·N.
- Frame length is F = 10·N cycles, or 11·N with parity.
- Completion at edge k+F:
  - State becomes IDLE, `o_tx_ready` becomes 1, and `o_tx_done` is high for exactly the cycle after k+F.
- Back-to-back bytes:
  - The earliest re-accept is edge k+F+1, so the stop bit lasts N+1 cycles.
  - There is no other inter-frame gap.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in. Frame is start, 8 data, even parity, stop (8E1, 11·N cycles).
- Undefined: the PARITY state and parity logic are absent. Frame is 8N1 (10·N cycles).

## Test plan
- **Reset:** hold `i_rst_n`=0 for 5 cycles with `i_tx_valid`=1 → `o_uart_tx`=1, `o_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0, and no frame starts.
- **Single byte, defaults:** send 0xA5 → line samples at the centre of each 434-cycle bit read 0,1,0,1,0,0,1,0,1,1. `o_tx_done` pulses once, 4340 cycles after accept.
- **Back-to-back:** hold `i_tx_valid`=1 with 0x00 then 0xFF → two frames. The stop bit between them is 435 cycles, and the second frame's data bits are all 1.
- **Valid while busy:** pulse `i_tx_valid` with 0x3C mid-frame of 0x81 → 0x3C is ignored, and only the 0x81 frame appears.
- **Mid-frame reset:** assert reset during data bit 3 of 0x55 → line is 1 at the next edge, no `o_tx_done`, and a fresh 0x12 sent afterwards frames correctly.
- **`UART_TX_PARITY_EN` defined:**
  - 0x07 → parity bit 1, frame 4774 cycles.
  - 0x03 → parity bit 0.
